ddr_arbiter: RTL and testbench

//   Shares the single DDR request port between instruction fetch (IF) and load/store (LS).
//   IF is the PC index requester: valid held until a ready pulse.

---
 rtl/ddr_arb_pkg.sv | 20 ++
 rtl/ddr_arb_if.sv | 48 ++++
 rtl/ddr_arb_pick.sv | 36 +++
 rtl/ddr_arbiter.sv | 154 +++++++++++++++
 tb/tb_ddr_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR port arbiter between
// instruction fetch and load/store.
package ddr_arb_pkg;

  localparam int DEF_INDEX_W = 19;
  localparam int DEF_DATA_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS,
    DRAIN
  } arb_state_e;

  typedef enum logic {
    REQ_IF,
    REQ_LS
  } req_id_e;

endpackage

// File: rtl/ddr_arb_if.sv
// Bundle of the IF, LS and DDR handshake signals around the arbiter.
// slave: the arbiter's view; master: the surrounding requesters and DDR.
interface ddr_arb_if #(
  parameter int INDEX_W = ddr_arb_pkg::DEF_INDEX_W,
  parameter int DATA_W  = ddr_arb_pkg::DEF_DATA_W
);

  logic                if_valid;
  logic [INDEX_W-1:0]  if_index;
  logic                if_flush;
  logic                if_ready;
  logic [DATA_W-1:0]   if_rdata;

  logic                ls_valid;
  logic                ls_write;
  logic [INDEX_W-1:0]  ls_index;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W/8-1:0] ls_wmask;
  logic                ls_ready;
  logic [DATA_W-1:0]   ls_rdata;

  logic                ddr_valid;
  logic                ddr_write;
  logic [INDEX_W-1:0]  ddr_index;
  logic [DATA_W-1:0]   ddr_wdata;
  logic [DATA_W/8-1:0] ddr_wmask;
  logic                ddr_ready;
  logic [DATA_W-1:0]   ddr_rdata;

  modport slave (
    input  if_valid, if_index, if_flush,
    output if_ready, if_rdata,
    input  ls_valid, ls_write, ls_index, ls_wdata, ls_wmask,
    output ls_ready, ls_rdata,
    output ddr_valid, ddr_write, ddr_index, ddr_wdata, ddr_wmask,
    input  ddr_ready, ddr_rdata
  );

  modport master (
    output if_valid, if_index, if_flush,
    input  if_ready, if_rdata,
    output ls_valid, ls_write, ls_index, ls_wdata, ls_wmask,
    input  ls_ready, ls_rdata,
    input  ddr_valid, ddr_write, ddr_index, ddr_wdata, ddr_wmask,
    output ddr_ready, ddr_rdata
  );

endinterface

// File: rtl/ddr_arb_pick.sv
// Combinational grant picker. DDR_ARB_RR_EN selects round-robin on conflict;
// otherwise LS has fixed priority and last_grant is ignored.
module ddr_arb_pick
  import ddr_arb_pkg::*;
(
  input  logic    if_req_i,
  input  logic    ls_req_i,
  input  req_id_e last_grant_i,
  output logic    grant_vld_o,
  output req_id_e grant_id_o
);

`ifdef DDR_ARB_RR_EN
  always_comb begin
    grant_vld_o = if_req_i | ls_req_i;
    grant_id_o  = REQ_LS;
    if (if_req_i && ls_req_i) begin
      grant_id_o = (last_grant_i == REQ_LS) ? REQ_IF : REQ_LS;
    end else if (if_req_i) begin
      grant_id_o = REQ_IF;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant_i == REQ_IF);

  always_comb begin
    grant_vld_o = if_req_i | ls_req_i;
    grant_id_o  = REQ_LS;
    if (if_req_i && !ls_req_i) begin
      grant_id_o = REQ_IF;
    end
  end
`endif

endmodule

// File: rtl/ddr_arbiter.sv
// Shares one DDR request port between IF and LS, one access at a time.
// Arbitration mode set by DDR_ARB_RR_EN (see ddr_arb_pick).
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input logic      clk,
  input logic      rst_n,
  ddr_arb_if.slave bus
);

  arb_state_e          state_q, state_d;
  req_id_e             last_grant_q, last_grant_d;
  logic                if_ready_q, if_ready_d;
  logic                ls_ready_q, ls_ready_d;
  logic                if_mask_q, if_mask_d;
  logic                ls_mask_q, ls_mask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                ddr_valid_q, ddr_valid_d;
  logic                ddr_write_q, ddr_write_d;
  logic [INDEX_W-1:0]  ddr_index_q, ddr_index_d;
  logic [DATA_W-1:0]   ddr_wdata_q, ddr_wdata_d;
  logic [DATA_W/8-1:0] ddr_wmask_q, ddr_wmask_d;

  logic    if_req, ls_req, grant_vld;
  req_id_e grant_id;

  // Requesters see ready one edge late and drop valid one edge after that,
  // so valid is ignored both in the ready cycle and the one following it.
  assign if_req = bus.if_valid & ~bus.if_flush & ~(if_ready_q | if_mask_q);
  assign ls_req = bus.ls_valid & ~(ls_ready_q | ls_mask_q);

  ddr_arb_pick u_pick (
    .if_req_i     (if_req),
    .ls_req_i     (ls_req),
    .last_grant_i (last_grant_q),
    .grant_vld_o  (grant_vld),
    .grant_id_o   (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_LS;
      if_ready_q   <= 1'b0;
      ls_ready_q   <= 1'b0;
      if_mask_q    <= 1'b0;
      ls_mask_q    <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      ddr_valid_q  <= 1'b0;
      ddr_write_q  <= 1'b0;
      ddr_index_q  <= '0;
      ddr_wdata_q  <= '0;
      ddr_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if_ready_q   <= if_ready_d;
      ls_ready_q   <= ls_ready_d;
      if_mask_q    <= if_mask_d;
      ls_mask_q    <= ls_mask_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      ddr_valid_q  <= ddr_valid_d;
      ddr_write_q  <= ddr_write_d;
      ddr_index_q  <= ddr_index_d;
      ddr_wdata_q  <= ddr_wdata_d;
      ddr_wmask_q  <= ddr_wmask_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if_ready_d   = 1'b0;
    ls_ready_d   = 1'b0;
    if_mask_d    = if_ready_q;
    ls_mask_d    = ls_ready_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    ddr_valid_d  = ddr_valid_q;
    ddr_write_d  = ddr_write_q;
    ddr_index_d  = ddr_index_q;
    ddr_wdata_d  = ddr_wdata_q;
    ddr_wmask_d  = ddr_wmask_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          last_grant_d = grant_id;
          ddr_valid_d  = 1'b1;
          if (grant_id == REQ_LS) begin
            ddr_write_d = bus.ls_write;
            ddr_index_d = bus.ls_index;
            ddr_wdata_d = bus.ls_wdata;
            ddr_wmask_d = bus.ls_wmask;
            state_d     = BUSY_LS;
          end else begin
            ddr_write_d = 1'b0;
            ddr_index_d = bus.if_index;
            ddr_wdata_d = '0;
            ddr_wmask_d = '0;
            state_d     = BUSY_IF;
          end
        end
      end
      BUSY_IF: begin
        if (bus.ddr_ready) begin
          ddr_valid_d = 1'b0;
          state_d     = IDLE;
          // A flush landing with the completion still discards the data.
          if (!bus.if_flush) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.ddr_rdata;
          end
        end else if (bus.if_flush) begin
          state_d = DRAIN;
        end
      end
      BUSY_LS: begin
        if (bus.ddr_ready) begin
          ddr_valid_d = 1'b0;
          ls_ready_d  = 1'b1;
          state_d     = IDLE;
          if (!ddr_write_q) begin
            ls_rdata_d = bus.ddr_rdata;
          end
        end
      end
      DRAIN: begin
        if (bus.ddr_ready) begin
          ddr_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_ready  = ls_ready_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ddr_valid = ddr_valid_q;
  assign bus.ddr_write = ddr_write_q;
  assign bus.ddr_index = ddr_index_q;
  assign bus.ddr_wdata = ddr_wdata_q;
  assign bus.ddr_wmask = ddr_wmask_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter; expectations follow DDR_ARB_RR_EN when defined.
module tb_ddr_arbiter;
  import ddr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_if_rdata = '0;
  logic [63:0] exp_ls_rdata = '0;

  ddr_arb_if bus ();

  ddr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid = 1'b0; bus.if_index = '0; bus.if_flush = 1'b0;
    bus.ls_valid = 1'b0; bus.ls_write = 1'b0; bus.ls_index = '0;
    bus.ls_wdata = '0;   bus.ls_wmask = '0;
    bus.ddr_ready = 1'b0; bus.ddr_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    exp_if_rdata = '0;
    exp_ls_rdata = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL rst_ddr_valid: got %b want 0", bus.ddr_valid); end
    checks++; if ({bus.if_ready, bus.ls_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {bus.if_ready, bus.ls_ready}); end
    checks++; if ({bus.if_rdata, bus.ls_rdata} !== 128'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {bus.if_rdata, bus.ls_rdata}); end
    checks++; if ({bus.ddr_write, bus.ddr_index, bus.ddr_wdata, bus.ddr_wmask} !== '0) begin errors++; $display("FAIL rst_ddr_bus: got %h want 0", {bus.ddr_write, bus.ddr_index, bus.ddr_wdata, bus.ddr_wmask}); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_if_read();
    bus.if_valid = 1'b1; bus.if_index = 19'h00040;
    tick();
    checks++; if (bus.ddr_valid !== 1'b1) begin errors++; $display("FAIL t1_ddr_valid: got %b want 1", bus.ddr_valid); end
    checks++; if (bus.ddr_index !== 19'h00040) begin errors++; $display("FAIL t1_ddr_index: got %h want 00040", bus.ddr_index); end
    checks++; if (bus.ddr_write !== 1'b0) begin errors++; $display("FAIL t1_ddr_write: got %b want 0", bus.ddr_write); end
    tick(); tick();
    checks++; if (bus.ddr_valid !== 1'b1 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL t1_hold: got valid=%b ready=%b want 1/0", bus.ddr_valid, bus.if_ready); end
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'hDEAD_BEEF;
    tick();
    bus.ddr_ready = 1'b0; bus.ddr_rdata = '0;
    exp_if_rdata = 64'hDEAD_BEEF;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL t1_if_ready: got %b want 1", bus.if_ready); end
    checks++; if (bus.if_rdata !== exp_if_rdata) begin errors++; $display("FAIL t1_if_rdata: got %h want %h", bus.if_rdata, exp_if_rdata); end
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t1_ddr_drop: got %b want 0", bus.ddr_valid); end
    tick();
    bus.if_valid = 1'b0;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL t1_single_pulse: got %b want 0", bus.if_ready); end
    tick();
  endtask

  task automatic test_ls_write();
    bus.ls_valid = 1'b1; bus.ls_write = 1'b1; bus.ls_index = 19'h00123;
    bus.ls_wdata = 64'h1122_3344_5566_7788; bus.ls_wmask = 8'h0F;
    tick();
    checks++; if (bus.ddr_valid !== 1'b1 || bus.ddr_write !== 1'b1) begin errors++; $display("FAIL t2_req: got valid=%b write=%b want 1/1", bus.ddr_valid, bus.ddr_write); end
    checks++; if (bus.ddr_index !== 19'h00123) begin errors++; $display("FAIL t2_index: got %h want 00123", bus.ddr_index); end
    checks++; if (bus.ddr_wdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL t2_wdata: got %h want 1122334455667788", bus.ddr_wdata); end
    checks++; if (bus.ddr_wmask !== 8'h0F) begin errors++; $display("FAIL t2_wmask: got %h want 0f", bus.ddr_wmask); end
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    bus.ddr_ready = 1'b0; bus.ddr_rdata = '0;
    checks++; if (bus.ls_ready !== 1'b1) begin errors++; $display("FAIL t2_ls_ready: got %b want 1", bus.ls_ready); end
    checks++; if (bus.ls_rdata !== exp_ls_rdata) begin errors++; $display("FAIL t2_ls_rdata_hold: got %h want %h", bus.ls_rdata, exp_ls_rdata); end
    tick();
    bus.ls_valid = 1'b0; bus.ls_write = 1'b0;
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t2_no_dup: got %b want 0", bus.ddr_valid); end
    tick();
  endtask

  task automatic test_conflict();
    logic first_if;
    logic [18:0] idx_first, idx_second;
`ifdef DDR_ARB_RR_EN
    first_if = 1'b1;
`else
    first_if = 1'b0;
`endif
    idx_first  = first_if ? 19'h000AA : 19'h000BB;
    idx_second = first_if ? 19'h000BB : 19'h000AA;
    apply_reset();
    bus.if_valid = 1'b1; bus.if_index = 19'h000AA;
    bus.ls_valid = 1'b1; bus.ls_write = 1'b0; bus.ls_index = 19'h000BB;
    tick();
    checks++; if (bus.ddr_index !== idx_first) begin errors++; $display("FAIL t3_first_index: got %h want %h", bus.ddr_index, idx_first); end
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h1111;
    tick();
    bus.ddr_ready = 1'b0;
    if (first_if) exp_if_rdata = 64'h1111; else exp_ls_rdata = 64'h1111;
    checks++; if ({bus.if_ready, bus.ls_ready} !== {first_if, ~first_if}) begin errors++; $display("FAIL t3_first_ready: got %b want %b", {bus.if_ready, bus.ls_ready}, {first_if, ~first_if}); end
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t3_turnaround: got %b want 0", bus.ddr_valid); end
    tick();
    if (first_if) bus.if_valid = 1'b0; else bus.ls_valid = 1'b0;
    checks++; if (bus.ddr_valid !== 1'b1 || bus.ddr_index !== idx_second) begin errors++; $display("FAIL t3_second_grant: got valid=%b index=%h want 1/%h", bus.ddr_valid, bus.ddr_index, idx_second); end
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h2222;
    tick();
    bus.ddr_ready = 1'b0;
    if (first_if) exp_ls_rdata = 64'h2222; else exp_if_rdata = 64'h2222;
    checks++; if ({bus.if_ready, bus.ls_ready} !== {~first_if, first_if}) begin errors++; $display("FAIL t3_second_ready: got %b want %b", {bus.if_ready, bus.ls_ready}, {~first_if, first_if}); end
    checks++; if (bus.if_rdata !== exp_if_rdata || bus.ls_rdata !== exp_ls_rdata) begin errors++; $display("FAIL t3_rdata: got %h/%h want %h/%h", bus.if_rdata, bus.ls_rdata, exp_if_rdata, exp_ls_rdata); end
    tick();
    bus.if_valid = 1'b0; bus.ls_valid = 1'b0;
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t3_no_dup: got %b want 0", bus.ddr_valid); end
    tick();
  endtask

  task automatic test_flush();
    bus.if_valid = 1'b1; bus.if_index = 19'h00055;
    tick();
    bus.if_flush = 1'b1; bus.if_valid = 1'b0;
    bus.ls_valid = 1'b1; bus.ls_write = 1'b0; bus.ls_index = 19'h00077;
    tick();
    bus.if_flush = 1'b0;
    checks++; if (dut.state_q !== DRAIN) begin errors++; $display("FAIL t4_drain: got %0d want %0d", dut.state_q, DRAIN); end
    checks++; if (bus.ddr_valid !== 1'b1 || bus.ddr_index !== 19'h00055) begin errors++; $display("FAIL t4_hold: got valid=%b index=%h want 1/00055", bus.ddr_valid, bus.ddr_index); end
    tick();
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h5A5A;
    tick();
    bus.ddr_ready = 1'b0;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL t4_no_if_ready: got %b want 0", bus.if_ready); end
    checks++; if (bus.if_rdata !== exp_if_rdata) begin errors++; $display("FAIL t4_if_rdata: got %h want %h", bus.if_rdata, exp_if_rdata); end
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t4_drop: got %b want 0", bus.ddr_valid); end
    tick();
    checks++; if (bus.ddr_valid !== 1'b1 || bus.ddr_index !== 19'h00077 || bus.ddr_write !== 1'b0) begin errors++; $display("FAIL t4_ls_grant: got valid=%b index=%h write=%b want 1/00077/0", bus.ddr_valid, bus.ddr_index, bus.ddr_write); end
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'hCAFE;
    tick();
    bus.ddr_ready = 1'b0;
    exp_ls_rdata = 64'hCAFE;
    checks++; if (bus.ls_ready !== 1'b1 || bus.ls_rdata !== exp_ls_rdata) begin errors++; $display("FAIL t4_ls_done: got ready=%b rdata=%h want 1/%h", bus.ls_ready, bus.ls_rdata, exp_ls_rdata); end
    tick();
    bus.ls_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_coincident();
    bus.if_valid = 1'b1; bus.if_index = 19'h00066;
    tick();
    tick();
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h9999; bus.if_flush = 1'b1; bus.if_valid = 1'b0;
    tick();
    bus.ddr_ready = 1'b0; bus.if_flush = 1'b0;
    checks++; if (bus.if_ready !== 1'b0 || bus.if_rdata !== exp_if_rdata) begin errors++; $display("FAIL t4b_coincident: got ready=%b rdata=%h want 0/%h", bus.if_ready, bus.if_rdata, exp_if_rdata); end
    checks++; if (bus.ddr_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL t4b_idle: got valid=%b state=%0d want 0/%0d", bus.ddr_valid, dut.state_q, IDLE); end
    tick();
  endtask

  task automatic test_idle_cases();
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h7777;
    tick();
    bus.ddr_ready = 1'b0;
    checks++; if ({bus.if_ready, bus.ls_ready, bus.ddr_valid} !== 3'b000) begin errors++; $display("FAIL spurious_ready: got %b want 000", {bus.if_ready, bus.ls_ready, bus.ddr_valid}); end
    checks++; if (bus.if_rdata !== exp_if_rdata || bus.ls_rdata !== exp_ls_rdata) begin errors++; $display("FAIL spurious_rdata: got %h/%h want %h/%h", bus.if_rdata, bus.ls_rdata, exp_if_rdata, exp_ls_rdata); end
    bus.if_valid = 1'b1; bus.if_index = 19'h00011; bus.if_flush = 1'b1;
    tick();
    bus.if_valid = 1'b0; bus.if_flush = 1'b0;
    checks++; if (bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL idle_flush: got %b want 0", bus.ddr_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.if_valid = 1'b1; bus.if_index = 19'h00100;
    tick();
    bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h0B2B;
    tick();
    bus.ddr_ready = 1'b0;
    exp_if_rdata = 64'h0B2B;
    checks++; if (bus.if_ready !== 1'b1 || bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t5_done: got ready=%b valid=%b want 1/0", bus.if_ready, bus.ddr_valid); end
    tick();
    checks++; if (bus.ddr_valid !== 1'b0 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL t5_masked: got valid=%b ready=%b want 0/0", bus.ddr_valid, bus.if_ready); end
    bus.if_valid = 1'b0;
    tick();
    checks++; if (bus.ddr_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL t5_no_dup: got valid=%b state=%0d want 0/%0d", bus.ddr_valid, dut.state_q, IDLE); end
  endtask

  task automatic test_reset_mid_access();
    bus.ls_valid = 1'b1; bus.ls_write = 1'b0; bus.ls_index = 19'h000CC;
    tick();
    checks++; if (dut.state_q !== BUSY_LS || bus.ddr_valid !== 1'b1) begin errors++; $display("FAIL t6_busy: got state=%0d valid=%b want %0d/1", dut.state_q, bus.ddr_valid, BUSY_LS); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ddr_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL t6_async: got valid=%b state=%0d want 0/%0d", bus.ddr_valid, dut.state_q, IDLE); end
    bus.ls_valid = 1'b0; bus.ddr_ready = 1'b1; bus.ddr_rdata = 64'h4444;
    tick();
    bus.ddr_ready = 1'b0;
    rst_n = 1'b1;
    exp_ls_rdata = '0;
    exp_if_rdata = '0;
    tick();
    checks++; if (bus.ls_ready !== 1'b0 || bus.ls_rdata !== exp_ls_rdata) begin errors++; $display("FAIL t6_no_ready: got ready=%b rdata=%h want 0/%h", bus.ls_ready, bus.ls_rdata, exp_ls_rdata); end
    tick();
    checks++; if (bus.ls_ready !== 1'b0 || bus.ddr_valid !== 1'b0) begin errors++; $display("FAIL t6_quiet: got ready=%b valid=%b want 0/0", bus.ls_ready, bus.ddr_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_if_read();
    test_ls_write();
    test_conflict();
    test_flush();
    test_flush_coincident();
    test_idle_cases();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
